// File: rtl/change_dispenser.sv
// Soda vend + coin change dispenser controller: runs the vend motor, then ejects
// the requested coins one by one, confirming each through the hopper exit sensor.
module change_dispenser #(
    parameter int VEND_CYCLES    = 4,
    parameter int EJECT_CYCLES   = 2,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       release_soda,
    input  logic [2:0] change,
    input  logic       coin_seen,
    input  logic       clear_jam,
    output logic       vend_motor,
    output logic       coin_eject,
    output logic       busy,
    output logic       done,
    output logic       jam,
    output logic [2:0] coins_left
);

    localparam int CW = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        VEND       = 3'd1,
        EJECT      = 3'd2,
        WAIT_SENSE = 3'd3,
        GAP        = 3'd4,
        DONE       = 3'd5,
        JAM        = 3'd6
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_nxt_s;
    logic            seen_r;
    logic            seen_nxt_s;
    logic [2:0]      coins_nxt_s;
    logic            cnt_zero_s;

    assign cnt_zero_s = (cnt_r == {CW{1'b0}});

    // Next-state logic; each phase counter is loaded with length-1 and the phase ends when it reaches zero
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        seen_nxt_s  = seen_r;
        coins_nxt_s = coins_left;
        case (state_r)
            IDLE: begin
                if (release_soda) begin
                    state_nxt_s = VEND;
                    cnt_nxt_s   = CW'(VEND_CYCLES - 1);
                    coins_nxt_s = change;
                end else begin
                    cnt_nxt_s = {CW{1'b0}};
                end
            end
            VEND: begin
                if (!cnt_zero_s) begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end else if (coins_left != 3'd0) begin
                    state_nxt_s = EJECT;
                    cnt_nxt_s   = CW'(EJECT_CYCLES - 1);
                    seen_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            EJECT: begin
                // A coin can clear the sensor while the solenoid is still firing
                seen_nxt_s = seen_r | coin_seen;
                if (!cnt_zero_s) begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end else begin
                    state_nxt_s = WAIT_SENSE;
                    cnt_nxt_s   = CW'(TIMEOUT_CYCLES - 1);
                end
            end
            WAIT_SENSE: begin
                if ((seen_r || coin_seen) && (coins_left != 3'd0)) begin
                    seen_nxt_s  = 1'b0;
                    coins_nxt_s = coins_left - 3'd1;
                    if (coins_left == 3'd1) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = GAP;
                        cnt_nxt_s   = CW'(GAP_CYCLES - 1);
                    end
                end else if (cnt_zero_s) begin
                    state_nxt_s = JAM;
                end else begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end
            end
            GAP: begin
                if (!cnt_zero_s) begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end else begin
                    state_nxt_s = EJECT;
                    cnt_nxt_s   = CW'(EJECT_CYCLES - 1);
                    seen_nxt_s  = 1'b0;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            JAM: begin
                if (clear_jam) begin
                    state_nxt_s = GAP;
                    cnt_nxt_s   = CW'(GAP_CYCLES - 1);
                end else begin
                    state_nxt_s = JAM;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CW{1'b0}};
                seen_nxt_s  = 1'b0;
                coins_nxt_s = 3'd0;
            end
        endcase
    end

    // State registers; outputs are decoded from the next state so they are registered
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            seen_r     <= 1'b0;
            coins_left <= 3'd0;
            vend_motor <= 1'b0;
            coin_eject <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            jam        <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            seen_r     <= seen_nxt_s;
            coins_left <= coins_nxt_s;
            vend_motor <= (state_nxt_s == VEND);
            coin_eject <= (state_nxt_s == EJECT);
            busy       <= (state_nxt_s != IDLE);
            done       <= (state_nxt_s == DONE);
            jam        <= (state_nxt_s == JAM);
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: expected outputs are packed as
// {vend_motor, coin_eject, busy, done, jam, coins_left[2:0]}.
module tb_change_dispenser;

    logic       clock = 1'b0;
    logic       reset;
    logic       release_soda;
    logic [2:0] change;
    logic       coin_seen;
    logic       clear_jam;
    logic       vend_motor;
    logic       coin_eject;
    logic       busy;
    logic       done;
    logic       jam;
    logic [2:0] coins_left;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int eject_cyc = 0;
    int overlap_cnt = 0;

    change_dispenser dut (
        .clock        (clock),
        .reset        (reset),
        .release_soda (release_soda),
        .change       (change),
        .coin_seen    (coin_seen),
        .clear_jam    (clear_jam),
        .vend_motor   (vend_motor),
        .coin_eject   (coin_eject),
        .busy         (busy),
        .done         (done),
        .jam          (jam),
        .coins_left   (coins_left)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (vend_motor && coin_eject) overlap_cnt++;
        if (done) done_cnt++;
        if (coin_eject) eject_cyc++;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] ex(input logic vm, input logic ce, input logic bs,
                                      input logic dn, input logic jm, input logic [2:0] c);
        return {vm, ce, bs, dn, jm, c};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_o(input string tag, input logic [7:0] exp);
        chk(tag, {vend_motor, coin_eject, busy, done, jam, coins_left}, exp);
    endtask

    int d0;
    int e0;

    initial begin
        reset = 1'b0; release_soda = 1'b0; change = 3'd0;
        coin_seen = 1'b0; clear_jam = 1'b0;
        #12;
        chk_o("reset_state", ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        @(posedge clock); #1;
        reset = 1'b1;
        tick;
        chk_o("idle_after_reset", ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));

        // change=0: vend only
        d0 = done_cnt; e0 = eject_cyc;
        release_soda = 1'b1; change = 3'd0;
        tick;
        release_soda = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk_o("c0_vend", ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0));
            tick;
        end
        chk_o("c0_done", ex(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
        tick;
        chk_o("c0_idle", ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        chk("c0_done_count", 8'(done_cnt - d0), 8'd1);
        chk("c0_no_eject", 8'(eject_cyc - e0), 8'd0);

        // change=2, sensor pulsed right after each eject
        d0 = done_cnt;
        release_soda = 1'b1; change = 3'd2;
        tick;
        release_soda = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk_o("c2_vend", ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2));
            tick;
        end
        for (int k = 2; k >= 1; k--) begin
            for (int i = 0; i < 2; i++) begin
                chk_o("c2_eject", ex(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'(k)));
                tick;
            end
            chk_o("c2_wait", ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'(k)));
            coin_seen = 1'b1;
            tick;
            coin_seen = 1'b0;
            if (k > 1) begin
                for (int i = 0; i < 2; i++) begin
                    chk_o("c2_gap", ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'(k - 1)));
                    tick;
                end
            end
        end
        chk_o("c2_done", ex(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
        tick;
        chk_o("c2_idle", ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        chk("c2_done_count", 8'(done_cnt - d0), 8'd1);

        // change=1, sensor silent -> jam, then clear and retry
        release_soda = 1'b1; change = 3'd1;
        tick;
        release_soda = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        for (int i = 0; i < 2; i++) begin
            chk_o("j_eject", ex(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1));
            tick;
        end
        for (int i = 0; i < 8; i++) begin
            chk_o("j_wait", ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1));
            tick;
        end
        chk_o("j_jam", ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1));
        coin_seen = 1'b1;
        tick;
        coin_seen = 1'b0;
        chk_o("j_jam_hold", ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1));
        clear_jam = 1'b1;
        tick;
        clear_jam = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk_o("j_gap", ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1));
            tick;
        end
        for (int i = 0; i < 2; i++) begin
            chk_o("j_retry_eject", ex(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1));
            tick;
        end
        coin_seen = 1'b1;
        tick;
        coin_seen = 1'b0;
        chk_o("j_done", ex(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
        tick;

        // change=5 with a second request during vend
        d0 = done_cnt;
        release_soda = 1'b1; change = 3'd5;
        tick;
        release_soda = 1'b0;
        tick;
        release_soda = 1'b1; change = 3'd3;
        tick;
        release_soda = 1'b0; change = 3'd0;
        chk_o("r_ignored", ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5));
        tick;
        tick;
        for (int k = 5; k >= 1; k--) begin
            for (int i = 0; i < 2; i++) begin
                chk_o("r_eject", ex(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'(k)));
                tick;
            end
            coin_seen = 1'b1;
            tick;
            coin_seen = 1'b0;
            if (k > 1) begin
                tick;
                tick;
            end
        end
        chk_o("r_done", ex(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
        tick;
        chk_o("r_idle", ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        chk("r_done_count", 8'(done_cnt - d0), 8'd1);

        // reset asserted mid-eject with three coins pending
        d0 = done_cnt;
        release_soda = 1'b1; change = 3'd3;
        tick;
        release_soda = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        chk_o("a_eject", ex(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3));
        #2 reset = 1'b0;
        #1 chk_o("a_async_clear", ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        tick;
        tick;
        reset = 1'b1;
        tick;
        tick;
        chk_o("a_idle", ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        chk("a_no_done", 8'(done_cnt - d0), 8'd0);

        // sensor held three clocks -> single decrement; then a sensor pulse inside eject is latched
        release_soda = 1'b1; change = 3'd2;
        tick;
        release_soda = 1'b0;
        for (int i = 0; i < 6; i++) tick;
        chk_o("h_wait", ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2));
        coin_seen = 1'b1;
        tick;
        chk_o("h_gap1", ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1));
        tick;
        tick;
        coin_seen = 1'b0;
        chk_o("h_eject_single_dec", ex(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1));
        coin_seen = 1'b1;
        tick;
        coin_seen = 1'b0;
        tick;
        chk_o("h_wait_latched", ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1));
        tick;
        chk_o("h_done", ex(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
        tick;

        chk("no_vend_eject_overlap", 8'(overlap_cnt), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter VEND_CYCLES, default 4, vend motor on-time in clocks (>=1).
REQ-002 Parameter EJECT_CYCLES, default 2, coin ejector solenoid pulse width in clocks (>=1).
REQ-003 Parameter GAP_CYCLES, default 2, idle clocks between consecutive coin ejections (>=1).
REQ-004 Parameter TIMEOUT_CYCLES, default 8, max clocks to wait for exit-sensor confirmation (>=1).
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low; 0 = reset asserted.
REQ-007 release_soda  input  1  vend request from sodamachine; sampled each rising edge.
REQ-008 change  input  3  coins to return (0-7), sampled only with an accepted release_soda.
REQ-009 coin_seen  input  1  hopper exit sensor; 1 = one coin has left the hopper.
REQ-010 clear_jam  input  1  operator acknowledge; acted on only in JAM.
REQ-011 vend_motor  output  1  drives soda vend motor.
REQ-012 coin_eject  output  1  drives coin ejector solenoid.
REQ-013 busy  output  1  1 in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on transaction completion.
REQ-015 jam  output  1  1 while in JAM.
REQ-016 coins_left  output  3  coins still to be dispensed.

Function
REQ-017 FSM states SHALL be IDLE, VEND, EJECT, WAIT_SENSE, GAP, DONE, JAM; all outputs registered.
REQ-018 IDLE: release_soda=1 at edge N -> coins_left<=change and state VEND; busy=1 from cycle N+1.
REQ-019 release_soda while busy=1 SHALL be ignored; no queuing, coins_left and state unaffected.
REQ-020 VEND: vend_motor=1 for exactly VEND_CYCLES clocks (cycles N+1..N+VEND_CYCLES); then EJECT if coins_left!=0, else DONE.
REQ-021 EJECT: coin_eject=1 for exactly EJECT_CYCLES clocks, then WAIT_SENSE.
REQ-022 coin_seen=1 during EJECT SHALL be latched and counted as confirmation on entry to WAIT_SENSE.
REQ-023 WAIT_SENSE: confirmation -> coins_left decrements by 1; next state DONE if new value 0, else GAP.
REQ-024 WAIT_SENSE: no confirmation within TIMEOUT_CYCLES clocks -> JAM; coins_left unchanged.
REQ-025 GAP: all drive outputs 0 for exactly GAP_CYCLES clocks, then EJECT.
REQ-026 At most one decrement per ejection; extra coin_seen pulses in same ejection ignored; coins_left never wraps below 0.
REQ-027 coin_seen in IDLE, VEND, GAP, DONE, JAM SHALL be ignored.
REQ-028 DONE: done=1 for one clock, busy=1, then IDLE.
REQ-029 JAM: jam=1, busy=1, vend_motor=coin_eject=0, coins_left held; clear_jam=1 -> GAP (retry remaining coins).
REQ-030 vend_motor and coin_eject SHALL never be 1 in the same cycle.
REQ-031 change=0 SHALL produce vend only, then DONE; no coin_eject pulse.

Reset
REQ-032 reset=0 SHALL immediately force IDLE, counters 0, coins_left=0, all outputs 0, independent of clock.
REQ-033 Reset mid-transaction SHALL abandon pending coins; no done pulse produced.
REQ-034 First accepted request is the first rising edge with reset=1 and release_soda=1.

Verification
REQ-035 Defaults, release_soda=1 change=0 at edge 0 -> vend_motor 1 cycles 1-4, done=1 cycle 5, busy=0 cycle 6, coin_eject never 1.
REQ-036 change=2, coin_seen pulsed 1 clock after each eject pulse -> two 2-cycle coin_eject pulses separated by >=2-cycle gap, coins_left 2->1->0, single done.
REQ-037 change=1, coin_seen never asserted -> jam=1 after 8 WAIT_SENSE clocks, coins_left=1; clear_jam -> GAP, then coin_eject pulses again.
REQ-038 release_soda re-asserted during VEND with change=5 -> ignored, coins_left keeps original value, exactly one done.
REQ-039 reset=0 asserted mid-EJECT with coins_left=3 -> coin_eject, busy, coins_left 0 asynchronously; IDLE after release, no done.
REQ-040 coin_seen held 1 for 3 clocks during one WAIT_SENSE -> coins_left decrements exactly once.
